// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// ps2_pkg : shared FSM encoding, PS/2 command/reply bytes, counter sizing
// Rev 1.0
// ============================================================================
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    INHIBIT    = 4'd1,
    REQ        = 4'd2,
    WAIT_START = 4'd3,
    SHIFT      = 4'd4,
    WAIT_ACK   = 4'd5,
    WAIT_IDLE  = 4'd6,
    DONE       = 4'd7,
    ERR        = 4'd8
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;
  localparam logic [7:0] BAT_OK       = 8'hAA;

  // Width of a counter that runs 0 .. count-1.
  function automatic int cnt_width(input int count);
    return (count < 2) ? 1 : $clog2(count);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
// ps2_host_tx_if : command request / status bundle of the PS/2 transmitter
// Rev 1.0
// ============================================================================
interface ps2_host_tx_if;
  logic [7:0] cmd_data;
  logic       cmd_send;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output cmd_data, output cmd_send,
                  input  busy, input done, input error);
  modport slave  (input  cmd_data, input cmd_send,
                  output busy, output done, output error);
endinterface
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// ps2_line_sync : 2-flop synchroniser with falling-edge detect for one line
// Rev 1.0
// ============================================================================
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Reset to the idle-high bus level so no spurious edge follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= line_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign line_sync = r_sync;
  assign line_fall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// ps2_host_tx : PS/2 host-to-device byte transmitter with ACK check
// Rev 1.0
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int FRAME_TIMEOUT  = 100000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  ps2_host_tx_if.slave       cmd,
  input  logic               ps2_clk_in,
  input  logic               ps2_dat_in,
  output logic               ps2_clk_oe,
  output logic               ps2_dat_oe
);

  localparam int c_CNT_MAX = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int c_CNT_W   = cnt_width(c_CNT_MAX);
  localparam int c_FRM_W   = cnt_width(FRAME_TIMEOUT);

  localparam logic [c_CNT_W-1:0] c_INHIBIT_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_START_LAST   = c_CNT_W'(START_TIMEOUT - 1);
  localparam logic [c_FRM_W-1:0] c_FRAME_LAST   = c_FRM_W'(FRAME_TIMEOUT - 1);

  logic w_clk_sync;
  logic w_clk_fall;
  logic w_dat_sync;
  logic w_dat_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk       (CLOCK_50),
    .rst       (reset),
    .line_in   (ps2_clk_in),
    .line_sync (w_clk_sync),
    .line_fall (w_clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk       (CLOCK_50),
    .rst       (reset),
    .line_in   (ps2_dat_in),
    .line_sync (w_dat_sync),
    .line_fall (w_dat_fall_unused)
  );

  ps2_state_t         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_FRM_W-1:0] r_frm_cnt;
  logic [3:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_parity;
  logic               r_clk_oe;
  logic               r_dat_oe;
  logic               r_busy;
  logic               r_done;
  logic               r_error;

  logic w_frame_expired;
  assign w_frame_expired = (r_frm_cnt == c_FRAME_LAST);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_frm_cnt <= '0;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'd0;
      r_parity  <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd.cmd_send) begin
            r_shift  <= cmd.cmd_data;
            r_parity <= ~^cmd.cmd_data;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_clk_oe <= 1'b1;
            r_dat_oe <= 1'b0;
            r_state  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (r_cnt == c_INHIBIT_LAST) begin
            r_cnt    <= '0;
            r_dat_oe <= 1'b1;
            r_state  <= REQ;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        REQ: begin
          r_clk_oe <= 1'b0;
          r_cnt    <= '0;
          r_state  <= WAIT_START;
        end
        WAIT_START: begin
          if (w_clk_fall) begin
            r_dat_oe  <= ~r_shift[0];
            r_bit_cnt <= 4'd1;
            r_frm_cnt <= '0;
            r_state   <= SHIFT;
          end else if (r_cnt == c_START_LAST) begin
            r_dat_oe <= 1'b0;
            r_error  <= 1'b1;
            r_state  <= ERR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SHIFT: begin
          r_frm_cnt <= r_frm_cnt + 1'b1;
          if (w_frame_expired) begin
            r_dat_oe <= 1'b0;
            r_error  <= 1'b1;
            r_state  <= ERR;
          end else if (r_bit_cnt == 4'd10) begin
            r_state <= WAIT_ACK;
          end else if (w_clk_fall) begin
            // Falls 2..10 present data bits 1..7, then parity, then release for stop.
            if (r_bit_cnt <= 4'd7) begin
              r_dat_oe <= ~r_shift[r_bit_cnt[2:0]];
            end else if (r_bit_cnt == 4'd8) begin
              r_dat_oe <= ~r_parity;
            end else begin
              r_dat_oe <= 1'b0;
            end
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        WAIT_ACK: begin
          r_frm_cnt <= r_frm_cnt + 1'b1;
          if (w_frame_expired) begin
            r_error <= 1'b1;
            r_state <= ERR;
          end else if (w_clk_fall) begin
            if (!w_dat_sync) begin
              r_state <= WAIT_IDLE;
            end else begin
              r_error <= 1'b1;
              r_state <= ERR;
            end
          end
        end
        WAIT_IDLE: begin
          r_frm_cnt <= r_frm_cnt + 1'b1;
          if (w_frame_expired) begin
            r_error <= 1'b1;
            r_state <= ERR;
          end else if (w_clk_sync && w_dat_sync) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE, ERR: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;
  assign cmd.busy   = r_busy;
  assign cmd.done   = r_done;
  assign cmd.error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// tb_ps2_host_tx : directed bench with a PS/2 device model and frame model
// Rev 1.0
// ============================================================================
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INHIBIT  = 5000;
  localparam int START_TO = 2000;
  localparam int FRAME_TO = 1000;
  localparam int HALF     = 20;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  logic dev_clk  = 1'b1;
  logic dev_dat  = 1'b1;
  logic ps2_clk_oe, ps2_dat_oe;
  logic clk_pin, dat_pin;

  assign clk_pin = dev_clk & ~ps2_clk_oe;
  assign dat_pin = dev_dat & ~ps2_dat_oe;

  ps2_host_tx_if cmd ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .START_TIMEOUT  (START_TO),
    .FRAME_TIMEOUT  (FRAME_TO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .cmd        (cmd.slave),
    .ps2_clk_in (clk_pin),
    .ps2_dat_in (dat_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;
  logic mon_en = 1'b0;

  always @(posedge CLOCK_50) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame as the device sees it: {stop, odd parity, data, start}.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  always @(negedge CLOCK_50) begin
    if (mon_en) begin
      chk("done_and_error", 32'(cmd.done & cmd.error), 32'd0);
      chk("pulse_width", 32'((cmd.done & prev_done) | (cmd.error & prev_err)), 32'd0);
      if (!cmd.busy)
        chk("idle_outputs", 32'({cmd.done, cmd.error, ps2_clk_oe, ps2_dat_oe}), 32'd0);
      if (cmd.done || cmd.error)
        chk("pulse_state", 32'({cmd.busy, ps2_clk_oe, ps2_dat_oe}), 32'b100);
      if (cmd.done) done_cnt++;
      if (cmd.error) err_cnt++;
      prev_done = cmd.done;
      prev_err  = cmd.error;
    end
  end

  task automatic send(input logic [7:0] b);
    cmd.cmd_data = b;
    cmd.cmd_send = 1'b1;
    @(negedge CLOCK_50);
    cmd.cmd_send = 1'b0;
    chk("busy_after_send", 32'(cmd.busy), 32'd1);
  endtask

  task automatic wait_req(output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < INHIBIT + 20; i++) begin
      if (!ok && ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) begin
        ok = 1'b1;
        t  = cyc;
      end
      if (!ok) @(negedge CLOCK_50);
    end
  endtask

  task automatic pulse_clk();
    dev_clk = 1'b0;
    repeat (HALF) @(negedge CLOCK_50);
    dev_clk = 1'b1;
  endtask

  // Device: start is sampled when the host releases clk, then 10 rising edges.
  task automatic device_xfer(input bit ack, output logic [10:0] bits);
    int t;
    bit ok;
    bits = '1;
    wait_req(t, ok);
    chk("device_saw_request", 32'(ok), 32'd1);
    if (ok) begin
      bits[0] = dat_pin;
      repeat (HALF) @(negedge CLOCK_50);
      for (int i = 1; i <= 10; i++) begin
        pulse_clk();
        bits[i] = dat_pin;
        repeat (HALF) @(negedge CLOCK_50);
      end
      if (ack) dev_dat = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      pulse_clk();
      repeat (HALF) @(negedge CLOCK_50);
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (cmd.done || cmd.error) seen = 1'b1;
      else @(negedge CLOCK_50);
    end
    chk("completion_seen", 32'(seen), 32'd1);
  endtask

  task automatic measure_inhibit();
    int n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < INHIBIT + 10) begin
      n++;
      @(negedge CLOCK_50);
    end
    chk("inhibit_cycles", 32'(n), 32'(INHIBIT));
    chk("req_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b11);
    @(negedge CLOCK_50);
    chk("wait_start_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b01);
  endtask

  initial begin
    #1800000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] bits;
    bit seen;
    int t;
    bit ok;

    cmd.cmd_data = 8'h00;
    cmd.cmd_send = 1'b0;

    // Model pinned against hand-computed frames.
    chk("model_ED", 32'(exp_frame(CMD_SET_LEDS)), 32'h7DA);
    chk("model_F4", 32'(exp_frame(CMD_ENABLE)), 32'h5E8);
    chk("model_00", 32'(exp_frame(8'h00)), 32'h600);

    repeat (3) @(negedge CLOCK_50);
    chk("reset_outputs", 32'({ps2_clk_oe, ps2_dat_oe, cmd.busy, cmd.done, cmd.error}), 32'd0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("post_reset_outputs", 32'({ps2_clk_oe, ps2_dat_oe, cmd.busy, cmd.done, cmd.error}), 32'd0);
    mon_en = 1'b1;

    // 0xED with inhibit timing.
    done_cnt = 0; err_cnt = 0;
    send(CMD_SET_LEDS);
    fork
      measure_inhibit();
      device_xfer(1'b1, bits);
    join
    chk("frame_ED", 32'(bits), 32'h7DA);
    wait_done(seen);
    @(negedge CLOCK_50);
    chk("busy_fall_ED", 32'(cmd.busy), 32'd0);
    chk("counts_ED", 32'({done_cnt[7:0], err_cnt[7:0]}), 32'h0100);

    // 0xF4, then 0x00 issued on the first idle cycle after DONE.
    done_cnt = 0; err_cnt = 0;
    send(CMD_ENABLE);
    device_xfer(1'b1, bits);
    chk("frame_F4", 32'(bits), 32'(exp_frame(CMD_ENABLE)));
    wait_done(seen);
    @(negedge CLOCK_50);
    chk("first_idle_busy", 32'(cmd.busy), 32'd0);
    send(8'h00);
    device_xfer(1'b1, bits);
    chk("frame_00", 32'(bits), 32'h600);
    repeat (30) @(negedge CLOCK_50);
    chk("counts_F4_00", 32'({done_cnt[7:0], err_cnt[7:0]}), 32'h0200);

    // Missing ACK.
    done_cnt = 0; err_cnt = 0;
    send(8'h3C);
    device_xfer(1'b0, bits);
    chk("frame_noack", 32'(bits), 32'(exp_frame(8'h3C)));
    repeat (30) @(negedge CLOCK_50);
    chk("counts_noack", 32'({done_cnt[7:0], err_cnt[7:0]}), 32'h0001);
    chk("lines_after_noack", 32'({ps2_clk_oe, ps2_dat_oe, cmd.busy}), 32'd0);

    // Device never clocks.
    done_cnt = 0; err_cnt = 0;
    send(BAT_OK);
    wait_req(t, ok);
    chk("timeout_req_seen", 32'(ok), 32'd1);
    for (int i = 0; i < START_TO + 20 && !cmd.error; i++) @(negedge CLOCK_50);
    chk("start_timeout_cycles", 32'(cyc - t), 32'(START_TO));
    chk("start_timeout_dat_oe", 32'(ps2_dat_oe), 32'd0);
    repeat (5) @(negedge CLOCK_50);
    chk("counts_timeout", 32'({done_cnt[7:0], err_cnt[7:0]}), 32'h0001);

    // cmd_send while busy is ignored.
    done_cnt = 0; err_cnt = 0;
    send(CMD_RESET);
    fork
      device_xfer(1'b1, bits);
      begin
        repeat (INHIBIT + 200) @(negedge CLOCK_50);
        cmd.cmd_data = 8'h11;
        cmd.cmd_send = 1'b1;
        @(negedge CLOCK_50);
        cmd.cmd_send = 1'b0;
      end
    join
    chk("frame_FF", 32'(bits), 32'h7FE);
    repeat (30) @(negedge CLOCK_50);
    chk("counts_FF", 32'({done_cnt[7:0], err_cnt[7:0]}), 32'h0100);
    chk("not_queued", 32'({cmd.busy, ps2_clk_oe}), 32'd0);

    // Asynchronous reset during SHIFT.
    done_cnt = 0; err_cnt = 0;
    send(CMD_ENABLE);
    wait_req(t, ok);
    repeat (HALF) @(negedge CLOCK_50);
    for (int i = 0; i < 3; i++) begin
      pulse_clk();
      repeat (HALF) @(negedge CLOCK_50);
    end
    dev_clk = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    chk("pre_reset_dat_oe", 32'(ps2_dat_oe), 32'd1);
    #3 reset = 1'b1;
    #1 chk("async_reset_lines", 32'({ps2_clk_oe, ps2_dat_oe, cmd.busy}), 32'd0);
    dev_clk = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("counts_reset", 32'({done_cnt[7:0], err_cnt[7:0]}), 32'h0000);
    send(CMD_ENABLE);
    device_xfer(1'b1, bits);
    chk("frame_F4_after_reset", 32'(bits), 32'h5E8);
    wait_done(seen);
    repeat (5) @(negedge CLOCK_50);
    chk("counts_after_reset", 32'({done_cnt[7:0], err_cnt[7:0]}), 32'h0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
